// File: rtl/ttl_cen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttl_cen_pkg : shared FSM encoding and ratio clamp for the Cen      |
// | sequencer.                       Rev 1.0                           |
// +--------------------------------------------------------------------+
package ttl_cen_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_STEP   = 2'd3
  } cen_state_t;

  localparam int unsigned MIN_DIV = 2;

  // Divide-by-1 would hold Cen_n low forever, so anything below 2 becomes 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? 32'(MIN_DIV) : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttl_cen_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttl_cen_channel : one divide counter with active/pending ratio     |
// | registers and the registered Cen_n strobe.   Rev 1.0               |
// +--------------------------------------------------------------------+
module ttl_cen_channel
  import ttl_cen_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_count_en,
  input  logic             i_sync,
  input  logic             i_wr_en,
  input  logic [DIV_W-1:0] i_wr_div,
`ifdef CEN_PHASE_EN
  input  logic [DIV_W-1:0] i_wr_phase,
`endif
  output logic             o_cen_n,
  output logic             o_tc
);

  localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pend_valid;
  logic             r_cen_n;
  logic             w_tc;
  logic [DIV_W-1:0] w_div_next;
  logic [DIV_W-1:0] w_sync_cnt;

  assign w_tc       = (r_cnt == (r_div_act - 1'b1));
  assign w_div_next = r_pend_valid ? r_div_pend : r_div_act;

`ifdef CEN_PHASE_EN
  logic [DIV_W-1:0] r_phase;

  // Phase is taken modulo the ratio that governs the period starting now.
  assign w_sync_cnt = r_phase % w_div_next;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_phase <= '0;
    end else if (i_wr_en) begin
      r_phase <= i_wr_phase;
    end
  end
`else
  assign w_sync_cnt = '0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt        <= '0;
      r_div_act    <= C_DEF_DIV;
      r_div_pend   <= C_DEF_DIV;
      r_pend_valid <= 1'b0;
      r_cen_n      <= 1'b1;
    end else begin
      r_cen_n <= ~(i_count_en & w_tc & ~i_sync);
      if (i_sync) begin
        r_cnt        <= w_sync_cnt;
        r_div_act    <= w_div_next;
        r_pend_valid <= 1'b0;
      end else if (i_count_en) begin
        if (w_tc) begin
          r_cnt        <= '0;
          r_div_act    <= w_div_next;
          r_pend_valid <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // A write on a boundary lands after the old pending value was consumed.
      if (i_wr_en) begin
        r_div_pend   <= i_wr_div;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign o_cen_n = r_cen_n;
  assign o_tc    = w_tc;

endmodule
`default_nettype wire

// File: rtl/ttl_cen_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ttl_cen_sequencer : per-channel Cen strobe scheduler with glitch-  |
// | free ratio updates and pause/step. Option macro: CEN_PHASE_EN.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ttl_cen_sequencer
  import ttl_cen_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef CEN_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  input  logic                sync,
  input  logic                pause_req,
  input  logic                step,
  output logic                pause_ack,
  output logic [CHANNELS-1:0] Cen_n,
  output logic [CHANNELS-1:0] tick
);

  cen_state_t          r_state;
  cen_state_t          w_state_nxt;
  logic                r_pause_ack;
  logic                w_count_en;
  logic                w_sel_ok;
  logic [DIV_W-1:0]    w_cfg_div;
  logic [CHANNELS-1:0] w_wr;
  logic [CHANNELS-1:0] w_tc;
  logic [CHANNELS-1:0] w_cen_n;
  logic                w_tc0;
  logic                w_unused_tc;

  assign w_cfg_div   = DIV_W'(clamp_div(32'(cfg_div)));
  assign w_sel_ok    = (32'(cfg_sel) < 32'(CHANNELS));
  assign w_tc0       = w_tc[0] & ~sync;
  assign w_unused_tc = ^w_tc;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_wr[gi] = cfg_we & w_sel_ok & (cfg_sel == SEL_W'(gi));

      ttl_cen_channel #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_count_en (w_count_en),
        .i_sync     (sync),
        .i_wr_en    (w_wr[gi]),
        .i_wr_div   (w_cfg_div),
`ifdef CEN_PHASE_EN
        .i_wr_phase (cfg_phase),
`endif
        .o_cen_n    (w_cen_n[gi]),
        .o_tc       (w_tc[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_count_en = 1'b1;
        if (pause_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_count_en = 1'b1;
        if (!pause_req)  w_state_nxt = ST_RUN;
        else if (w_tc0)  w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!pause_req)  w_state_nxt = ST_RUN;
        else if (step)   w_state_nxt = ST_STEP;
      end
      ST_STEP: begin
        w_count_en  = 1'b1;
        w_state_nxt = ST_PAUSED;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Ack stays high across single steps so the debugger sees one unbroken freeze.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= ST_RUN;
      r_pause_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_ack <= (w_state_nxt == ST_PAUSED) || (w_state_nxt == ST_STEP);
    end
  end

  assign pause_ack = r_pause_ack;
  assign Cen_n     = w_cen_n;
  assign tick      = ~w_cen_n;

endmodule
`default_nettype wire

// File: tb/tb_ttl_cen_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ttl_cen_sequencer : directed self-checking bench for the Cen    |
// | sequencer (4 channels, 8-bit ratios, default divide 4). Rev 1.0    |
// +--------------------------------------------------------------------+
module tb_ttl_cen_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_div = '0;
`ifdef CEN_PHASE_EN
  logic [7:0] cfg_phase = '0;
`endif
  logic       sync = 1'b0;
  logic       pause_req = 1'b0;
  logic       step = 1'b0;
  logic       pause_ack;
  logic [3:0] Cen_n;
  logic [3:0] tick;

  int n_chk  = 0;
  int n_pass = 0;
  int ncyc   = 0;

  always #5 Clk = ~Clk;

  ttl_cen_sequencer #(
    .CHANNELS    (4),
    .DIV_W       (8),
    .DEFAULT_DIV (4)
  ) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
`ifdef CEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .sync      (sync),
    .pause_req (pause_req),
    .step      (step),
    .pause_ack (pause_ack),
    .Cen_n     (Cen_n),
    .tick      (tick)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, ncyc);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    ncyc++;
  endtask

  logic [3:0] e;
  logic [3:0] sync_tab [10];

  initial begin
    // Reset state
    cyc();
    check("rst_cen_n", 32'(Cen_n), 32'hF);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_ack", 32'(pause_ack), 32'h0);
    Rst  = 1'b0;
    ncyc = 0;

    // Defaults: all channels strobe every 4th cycle, first at cycle 4
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("default_period", 32'(Cen_n), (ncyc % 4 == 0) ? 32'h0 : 32'hF);
      if (ncyc == 4) check("tick_copy", 32'(tick), 32'hF);
    end

    // ch1 -> 6 mid-period: current 4-cycle period completes first
    cfg_sel = 2'd1; cfg_div = 8'd6; cfg_we = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      cfg_we = 1'b0;
      e[0] = (ncyc % 4 != 0);
      e[1] = (ncyc <= 12) ? (ncyc % 4 != 0) : (ncyc % 6 != 0);
      e[2] = e[0];
      e[3] = e[0];
      check("ch1_div6", 32'(Cen_n), 32'(e));
    end

    // ch2 written with 1 then 0: both clamp to period 2
    cfg_sel = 2'd2; cfg_div = 8'd1; cfg_we = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) cfg_div = 8'd0;
      if (k == 1) cfg_we = 1'b0;
      e[0] = (ncyc % 4 != 0);
      e[1] = (ncyc % 6 != 0);
      e[2] = (ncyc >= 28) ? (ncyc % 2 != 0) : (ncyc % 4 != 0);
      e[3] = e[0];
      check("ch2_clamp", 32'(Cen_n), 32'(e));
    end

    // Pause requested with ch0 cnt=1
    cyc();
    pause_req = 1'b1;
    cyc(); check("drain_e38", 32'(Cen_n), 32'hB); check("drain_ack0", 32'(pause_ack), 32'h0);
    cyc(); check("drain_e39", 32'(Cen_n), 32'hF);
    cyc(); check("drain_strobe", 32'(Cen_n), 32'h2); check("pause_ack_set", 32'(pause_ack), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("paused_idle", 32'(Cen_n), 32'hF);
      check("paused_ack", 32'(pause_ack), 32'h1);
    end
    step = 1'b1; cyc(); step = 1'b0;
    check("step1_enter", 32'(Cen_n), 32'hF);
    cyc(); check("step1_count", 32'(Cen_n), 32'hF);
    cyc();
    step = 1'b1; cyc(); step = 1'b0;
    cyc(); check("step2_strobe", 32'(Cen_n), 32'h9);
    cyc();
    step = 1'b1; cyc(); cyc(); step = 1'b0;
    check("step3_count", 32'(Cen_n), 32'hF);
    cyc(); check("step_in_step_ignored", 32'(Cen_n), 32'hF);
    check("ack_after_steps", 32'(pause_ack), 32'h1);
    pause_req = 1'b0; step = 1'b1;
    cyc(); step = 1'b0;
    check("resume_ack0", 32'(pause_ack), 32'h0);
    check("resume_nocount", 32'(Cen_n), 32'hF);
    cyc(); check("resume_e54", 32'(Cen_n), 32'h2);
    cyc(); check("resume_e55", 32'(Cen_n), 32'hF);
    cyc(); check("resume_e56", 32'(Cen_n), 32'hB);
    cyc(); check("resume_e57", 32'(Cen_n), 32'hF);
    cyc(); check("resume_e58", 32'(Cen_n), 32'h0);

    // sync on a coincident terminal count: no strobe, all realigned
    sync_tab = '{4'hF, 4'hB, 4'hF, 4'hF, 4'hF, 4'hB, 4'hF, 4'h2, 4'hF, 4'h9};
    for (int k = 0; k < 10; k++) begin
      sync = (k == 3);
      cyc();
      sync = 1'b0;
      check("sync_realign", 32'(Cen_n), 32'(sync_tab[k]));
    end

    // ch3: pending 7 consumed by coincident strobe, 5 becomes pending
    cfg_sel = 2'd3;
    for (int k = 0; k < 15; k++) begin
      cfg_we  = (k < 2);
      cfg_div = (k == 0) ? 8'd7 : 8'd5;
      cyc();
      cfg_we = 1'b0;
      check("ch3_wr_tc", 32'(Cen_n[3]),
            (ncyc == 70 || ncyc == 77 || ncyc == 82) ? 32'h0 : 32'h1);
    end

    // sync applies a pending ratio immediately
    cfg_sel = 2'd0; cfg_div = 8'd3;
    for (int k = 0; k < 9; k++) begin
      cfg_we = (k == 0);
      sync   = (k == 1);
      cyc();
      cfg_we = 1'b0;
      sync   = 1'b0;
      check("sync_apply", 32'(Cen_n[0]), (ncyc == 88 || ncyc == 91) ? 32'h0 : 32'h1);
    end

    // Reset while in STEP aborts and restores defaults
    pause_req = 1'b1;
    for (int i = 0; i < 10 && !pause_ack; i++) cyc();
    check("pause_ack_wait", 32'(pause_ack), 32'h1);
    step = 1'b1; cyc(); step = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check("rst_step_ack", 32'(pause_ack), 32'h0);
    check("rst_step_cen", 32'(Cen_n), 32'hF);
    check("rst_step_tick", 32'(tick), 32'h0);
    pause_req = 1'b0;
    cyc();
    Rst  = 1'b0;
    ncyc = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("rst_restart", 32'(Cen_n), (ncyc == 4) ? 32'h0 : 32'hF);
    end

`ifdef CEN_PHASE_EN
    // ch1 phase 2: strobes two cycles ahead of ch0 after sync
    cfg_sel = 2'd1; cfg_div = 8'd4; cfg_phase = 8'd2;
    for (int k = 0; k < 6; k++) begin
      cfg_we = (k == 0);
      sync   = (k == 1);
      cyc();
      cfg_we = 1'b0;
      sync   = 1'b0;
      check("phase_skew", 32'(Cen_n),
            (ncyc == 8) ? 32'hD : (ncyc == 10) ? 32'h2 : 32'hF);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
